// File: rtl/mux_chk_pkg.sv
// Shared types and helpers for the mux vector checker.
// Holds the FSM encoding, sizing constants and the mux golden function.
package mux_chk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam int NUM_VECTORS = 8;
  localparam int CNT_W       = 8;

  function automatic logic mux_expected(
    input logic a,
    input logic b,
    input logic c
  );
    return (c & b) | (a & ~c);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mux_vector_checker_ref.sv
// Combinational golden model of the lab mux: z = (c&b)|(a&~c).
// Shared by the checker and usable directly from a bench.
module mux_ref_model
  import mux_chk_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic expected
);

  assign expected = mux_expected(a, b, c);

endmodule

// File: rtl/mux_vector_checker.sv
// Sweeps all {a,b,c} vectors into the lab mux and scores its z output.
// Optional fail_map output: define MUX_VECTOR_CHECKER_FAIL_MAP_EN.
module mux_vector_checker
  import mux_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int SWEEPS        = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             z,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             all_pass,
  output logic [2:0]       first_fail
`ifdef MUX_VECTOR_CHECKER_FAIL_MAP_EN
  ,
  output logic [NUM_VECTORS-1:0] fail_map
`endif
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] LAST_SWEEP  = 4'(SWEEPS - 1);

  state_t           state;
  state_t           state_n;
  logic [1:0]       rst_sync;
  logic             rst_i;
  logic [2:0]       vec;
  logic [3:0]       sweep;
  logic [3:0]       settle_cnt;
  logic             z_s;
  logic             got_fail;
  logic             exp_z;
  logic             mismatch;
  logic             last_vec;
  logic [CNT_W-1:0] fail_nxt;

  // Assert immediately, release on a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_sync <= 2'b11;
    end else begin
      rst_sync <= {rst_sync[0], 1'b0};
    end
  end

  assign rst_i = rst_sync[1];

  mux_ref_model u_ref (
    .a        (a),
    .b        (b),
    .c        (c),
    .expected (exp_z)
  );

  assign mismatch = (z_s != exp_z);
  assign last_vec = (vec == 3'd7) && (sweep == LAST_SWEEP);
  assign fail_nxt = mismatch ? sat_inc(fail_count) : fail_count;

  assign busy = (state == APPLY) || (state == SETTLE) ||
                (state == SAMPLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = APPLY;
      APPLY:   state_n = SETTLE;
      SETTLE:  if (settle_cnt == 4'd0) state_n = SAMPLE;
      SAMPLE:  state_n = last_vec ? DONE : APPLY;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      a          <= 1'b0;
      b          <= 1'b0;
      c          <= 1'b0;
      vec        <= 3'd0;
      sweep      <= 4'd0;
      settle_cnt <= 4'd0;
      z_s        <= 1'b0;
      got_fail   <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
      all_pass   <= 1'b0;
      first_fail <= 3'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            vec        <= 3'd0;
            sweep      <= 4'd0;
            got_fail   <= 1'b0;
            pass_count <= '0;
            fail_count <= '0;
            all_pass   <= 1'b0;
            first_fail <= 3'd0;
          end
        end
        APPLY: begin
          {a, b, c}  <= vec;
          settle_cnt <= SETTLE_LOAD;
        end
        SETTLE: begin
          // z is captured after exactly SETTLE_CYCLES stable clocks.
          if (settle_cnt == 4'd0) begin
            z_s <= z;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            fail_count <= fail_nxt;
            if (!got_fail) begin
              first_fail <= vec;
              got_fail   <= 1'b1;
            end
          end else begin
            pass_count <= sat_inc(pass_count);
          end
          vec <= vec + 3'd1;
          if (vec == 3'd7) sweep <= sweep + 4'd1;
          if (last_vec) all_pass <= (fail_nxt == '0);
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MUX_VECTOR_CHECKER_FAIL_MAP_EN
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      fail_map <= '0;
    end else if (state == IDLE && start) begin
      fail_map <= '0;
    end else if (state == SAMPLE && mismatch) begin
      fail_map[vec] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_vector_checker.sv
// Directed bench for mux_vector_checker: good and faulty mux models,
// multi-sweep timing, start while busy and reset mid-run.
module tb_mux_vector_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       start0;
  logic       start1;
  logic       a0, b0, c0, z0;
  logic       a1, b1, c1, z1;
  logic       busy0, done0, busy1, done1;
  logic [7:0] pass0, fail0, pass1, fail1;
  logic       allp0, allp1;
  logic [2:0] ff0, ff1;
`ifdef MUX_VECTOR_CHECKER_FAIL_MAP_EN
  logic [7:0] fmap0, fmap1;
`endif
  int         mode;
  int         checks = 0;
  int         errors = 0;
  logic [2:0] d1, d2, d3;

  always #5 clk = ~clk;

  function automatic logic gold(input logic a, b, c);
    return c ? b : a;
  endfunction

  // mode 0 good, 1 stuck-at-0, 2 inverted select, 3 stuck-at-1
  always_comb begin
    z0 = gold(a0, b0, c0);
    if (mode == 1) z0 = 1'b0;
    if (mode == 2) z0 = c0 ? a0 : b0;
    if (mode == 3) z0 = 1'b1;
  end

  // Slow mux: output valid only after four clocks of stable input.
  always_ff @(posedge clk) begin
    d1 <= {a1, b1, c1};
    d2 <= d1;
    d3 <= d2;
  end
  assign z1 = gold(d3[2], d3[1], d3[0]);

  mux_vector_checker #(.SETTLE_CYCLES(1), .SWEEPS(1)) u0 (
    .clk(clk), .reset(reset), .start(start0),
    .a(a0), .b(b0), .c(c0), .z(z0),
    .busy(busy0), .done(done0),
    .pass_count(pass0), .fail_count(fail0),
    .all_pass(allp0), .first_fail(ff0)
`ifdef MUX_VECTOR_CHECKER_FAIL_MAP_EN
    , .fail_map(fmap0)
`endif
  );

  mux_vector_checker #(.SETTLE_CYCLES(4), .SWEEPS(3)) u1 (
    .clk(clk), .reset(reset), .start(start1),
    .a(a1), .b(b1), .c(c1), .z(z1),
    .busy(busy1), .done(done1),
    .pass_count(pass1), .fail_count(fail1),
    .all_pass(allp1), .first_fail(ff1)
`ifdef MUX_VECTOR_CHECKER_FAIL_MAP_EN
    , .fail_map(fmap1)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Pulse start and count clocks (start edge = 1) until done.
  task automatic run(input int which, input int rep_at, output int lat);
    int n;
    @(negedge clk);
    if (which == 0) start0 = 1'b1;
    else start1 = 1'b1;
    @(posedge clk);
    #1;
    n = 1;
    start0 = 1'b0;
    start1 = 1'b0;
    chk("busy_rise", (which == 0) ? busy0 : busy1, 1);
    while (((which == 0) ? done0 : done1) !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (which == 0) start0 = (n == rep_at);
    end
    start0 = 1'b0;
    if (n >= 400) chk("done_timeout", 0, 1);
    lat = n;
  endtask

  typedef struct {
    int         mode;
    int         pass;
    int         fail;
    logic       allp;
    logic [2:0] ff;
    logic [7:0] fmap;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int   lat;
    logic saw_done;
    tbl[0] = '{0, 8, 0, 1'b1, 3'b000, 8'b0000_0000};
    tbl[1] = '{1, 4, 4, 1'b0, 3'b011, 8'b1101_1000};
    tbl[2] = '{2, 4, 4, 1'b0, 3'b010, 8'b0011_1100};
    tbl[3] = '{3, 4, 4, 1'b0, 3'b000, 8'b0010_0111};
    mode   = 0;
    start0 = 1'b0;
    start1 = 1'b0;
    reset  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_abc", {a0, b0, c0}, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_fail", fail0, 0);
    chk("rst_allp", allp0, 0);
    chk("rst_ff", ff0, 0);
    @(negedge clk) reset = 1'b0;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 4; i++) begin
      mode = tbl[i].mode;
      run(0, 0, lat);
      chk($sformatf("lat_m%0d", i), lat, 25);
      chk($sformatf("pass_m%0d", i), pass0, tbl[i].pass);
      chk($sformatf("fail_m%0d", i), fail0, tbl[i].fail);
      chk($sformatf("allp_m%0d", i), allp0, tbl[i].allp);
      chk($sformatf("ff_m%0d", i), ff0, tbl[i].ff);
      chk($sformatf("busy_done_m%0d", i), busy0, 0);
      chk($sformatf("abc_hold_m%0d", i), {a0, b0, c0}, 7);
`ifdef MUX_VECTOR_CHECKER_FAIL_MAP_EN
      chk($sformatf("fmap_m%0d", i), fmap0, tbl[i].fmap);
`endif
      @(posedge clk);
      #1;
      chk($sformatf("done_pulse_m%0d", i), done0, 0);
      chk($sformatf("allp_hold_m%0d", i), allp0, tbl[i].allp);
    end

    mode = 0;
    run(0, 5, lat);
    chk("rep_lat", lat, 25);
    chk("rep_pass", pass0, 8);
    chk("rep_fail", fail0, 0);

    run(1, 0, lat);
    chk("multi_lat", lat, 1 + 3 * 8 * 6);
    chk("multi_pass", pass1, 24);
    chk("multi_fail", fail1, 0);
    chk("multi_allp", allp1, 1);

    mode = 1;
    @(negedge clk) start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_busy", busy0, 0);
    chk("mid_done", done0, 0);
    chk("mid_abc", {a0, b0, c0}, 0);
    chk("mid_fail", fail0, 0);
    chk("mid_ff", ff0, 0);
`ifdef MUX_VECTOR_CHECKER_FAIL_MAP_EN
    chk("mid_fmap", fmap0, 0);
`endif
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      saw_done |= done0;
    end
    @(negedge clk) reset = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      saw_done |= done0;
    end
    chk("mid_no_done", saw_done, 0);
    mode = 0;
    run(0, 0, lat);
    chk("post_lat", lat, 25);
    chk("post_pass", pass0, 8);
    chk("post_allp", allp0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
